// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring divider for the RISC-V M-extension division ops
//   (DIV, DIVU, REM, REMU). It retires one quotient bit per cycle.
//   Divide-by-zero and signed overflow are resolved in a single cycle.
//
// Parameters
//   XLEN  : operand/result width (even, >= 8)
//   CNT_W : iteration counter width
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request a new operation (accepted in IDLE or DONE)
//   op     : funct3[1:0] -> 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a_in   : dividend
//   b_in   : divisor
//   flush  : abort any in-flight operation, no result produced
//   busy   : high while the iterative datapath is running
//   valid  : one-cycle pulse, c_out holds a fresh result
//   c_out  : result, held until the next completion
//
// Configuration macro
//   DIV_RESULT_CACHE_EN : when defined, remembers the last normal-case
//                         operands and results. A repeat of the same
//                         a/b/signedness completes in one cycle.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] c_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]  ZERO      = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES      = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ONE       = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg_cond(input logic [XLEN-1:0] v,
                                               input logic            neg);
    logic [XLEN-1:0] r;
    if (neg) begin
      r = ~v + ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t          state_r;
  logic            busy_r;
  logic            valid_r;
  logic [XLEN-1:0] c_out_r;
  logic [CNT_W-1:0] cnt_r;
  logic            rem_sel_r;   // op[1]: return remainder instead of quotient
  logic            q_neg_r;
  logic            r_neg_r;
  logic [XLEN-1:0] divisor_r;
  logic [XLEN-1:0] quot_r;      // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] rem_r;

  // Acceptance-side decode
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic            special_s;
  logic [XLEN-1:0] special_res_s;
  logic            cache_hit_s;
  logic [XLEN-1:0] cache_res_s;

  // Iteration datapath
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] rem_nxt_s;
  logic [XLEN-1:0] quot_nxt_s;
  logic [XLEN-1:0] q_final_s;
  logic [XLEN-1:0] r_final_s;
  logic [XLEN-1:0] res_s;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid_r;
  logic [XLEN-1:0] cache_a_r;
  logic [XLEN-1:0] cache_b_r;
  logic            cache_op0_r;
  logic [XLEN-1:0] cache_q_r;
  logic [XLEN-1:0] cache_r_r;
  logic [XLEN-1:0] a_raw_r;     // original operands of the in-flight op
  logic [XLEN-1:0] b_raw_r;
  logic            op0_r;
`endif

  assign busy  = busy_r;
  assign valid = valid_r;
  assign c_out = c_out_r;

  // Operand decode: magnitudes, special cases and cache lookup at acceptance.
  always_comb begin
    a_neg_s    = ~op[0] & a_in[XLEN-1];
    b_neg_s    = ~op[0] & b_in[XLEN-1];
    a_mag_s    = neg_cond(a_in, a_neg_s);
    b_mag_s    = neg_cond(b_in, b_neg_s);
    div_zero_s = (b_in == ZERO);
    ovf_s      = ~op[0] & (a_in == MIN_NEG) & (b_in == ONES);
    special_s  = div_zero_s | ovf_s;
    // Divide-by-zero takes priority over signed overflow.
    if (div_zero_s) begin
      special_res_s = op[1] ? a_in : ONES;
    end else if (ovf_s) begin
      special_res_s = op[1] ? ZERO : a_in;
    end else begin
      special_res_s = ZERO;
    end
`ifdef DIV_RESULT_CACHE_EN
    cache_hit_s = cache_valid_r & (a_in == cache_a_r) & (b_in == cache_b_r) &
                  (op[0] == cache_op0_r);
    cache_res_s = op[1] ? cache_r_r : cache_q_r;
`else
    cache_hit_s = 1'b0;
    cache_res_s = ZERO;
`endif
  end

  // One restoring shift-subtract step, plus the sign fix-up used on the last step.
  always_comb begin
    shifted_s = {rem_r, quot_r[XLEN-1]};
    trial_s   = shifted_s - {1'b0, divisor_r};
    if (trial_s[XLEN] == 1'b0) begin
      rem_nxt_s  = trial_s[XLEN-1:0];
      quot_nxt_s = {quot_r[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt_s  = shifted_s[XLEN-1:0];
      quot_nxt_s = {quot_r[XLEN-2:0], 1'b0};
    end
    q_final_s = neg_cond(quot_nxt_s, q_neg_r);
    r_final_s = neg_cond(rem_nxt_s, r_neg_r);
    if (rem_sel_r) begin
      res_s = r_final_s;
    end else begin
      res_s = q_final_s;
    end
  end

  // Control FSM with registered busy/valid/c_out and the iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      c_out_r   <= ZERO;
      cnt_r     <= CNT_ZERO;
      rem_sel_r <= 1'b0;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      divisor_r <= ZERO;
      quot_r    <= ZERO;
      rem_r     <= ZERO;
`ifdef DIV_RESULT_CACHE_EN
      cache_valid_r <= 1'b0;
      cache_a_r     <= ZERO;
      cache_b_r     <= ZERO;
      cache_op0_r   <= 1'b0;
      cache_q_r     <= ZERO;
      cache_r_r     <= ZERO;
      a_raw_r       <= ZERO;
      b_raw_r       <= ZERO;
      op0_r         <= 1'b0;
`endif
    end else if (flush) begin
      // Abort wins over everything, including a same-cycle start; c_out is kept.
      state_r <= IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            rem_sel_r <= op[1];
            if (special_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              valid_r <= 1'b1;
              c_out_r <= special_res_s;
            end else if (cache_hit_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              valid_r <= 1'b1;
              c_out_r <= cache_res_s;
            end else begin
              state_r   <= CALC;
              busy_r    <= 1'b1;
              valid_r   <= 1'b0;
              cnt_r     <= CNT_ZERO;
              q_neg_r   <= a_neg_s ^ b_neg_s;
              r_neg_r   <= a_neg_s;
              divisor_r <= b_mag_s;
              quot_r    <= a_mag_s;
              rem_r     <= ZERO;
`ifdef DIV_RESULT_CACHE_EN
              a_raw_r   <= a_in;
              b_raw_r   <= b_in;
              op0_r     <= op[0];
`endif
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
          end
        end
        CALC: begin
          quot_r <= quot_nxt_s;
          rem_r  <= rem_nxt_s;
          cnt_r  <= cnt_r + CNT_ONE;
          // The last step lands directly in DONE with the sign-corrected result.
          if (cnt_r == LAST_STEP) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
            c_out_r <= res_s;
`ifdef DIV_RESULT_CACHE_EN
            cache_valid_r <= 1'b1;
            cache_a_r     <= a_raw_r;
            cache_b_r     <= b_raw_r;
            cache_op0_r   <= op0_r;
            cache_q_r     <= q_final_s;
            cache_r_r     <= r_final_s;
`endif
          end else begin
            state_r <= CALC;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (XLEN=32). Expected results and the
//   cycle at which valid must appear are pushed to a scoreboard queue when a
//   start is driven. A negedge monitor pops and compares them on every valid.
//   Honours DIV_RESULT_CACHE_EN for expected latencies.
// -----------------------------------------------------------------------------
module tb_seq_divider;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int XLEN = 32;
  localparam int NORM_LAT = XLEN + 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [1:0]        op;
  logic [XLEN-1:0]   a_in;
  logic [XLEN-1:0]   b_in;
  logic              flush;
  logic              busy;
  logic              valid;
  logic [XLEN-1:0]   c_out;

  seq_divider #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a_in  (a_in),
    .b_in  (b_in),
    .flush (flush),
    .busy  (busy),
    .valid (valid),
    .c_out (c_out)
  );

  typedef struct {
    logic [XLEN-1:0] val;
    int              due;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            e;
  int              cyc;
  int              n_checks;
  int              n_errors;
  logic [XLEN-1:0] last_exp;

  // Reference cache model
  bit              cv;
  logic [XLEN-1:0] ca;
  logic [XLEN-1:0] cb;
  bit              co0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_res(input logic [1:0] o,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    if (b == 32'h0) begin
      r = o[1] ? a : 32'hFFFF_FFFF;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = o[1] ? 32'h0 : a;
    end else begin
      case (o)
        2'b00:   r = $signed(a) / $signed(b);
        2'b01:   r = a / b;
        2'b10:   r = $signed(a) % $signed(b);
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  // Monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("c_out", 64'(c_out), 64'(e.val));
        chk("latency", 64'(cyc), 64'(e.due));
        last_exp = e.val;
      end
    end
  end

  // Call at a negedge: drive one accepted op, push its expectation,
  // then scramble the inputs after acceptance.
  task automatic drive(input logic [1:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    exp_t x;
    bit   special;
    bit   hit;
    int   lat;
    special = (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit     = CACHE && !special && cv && a == ca && b == cb && o[0] == co0;
    lat     = (special || hit) ? 1 : NORM_LAT;
    if (!special && !hit) begin
      cv = 1'b1; ca = a; cb = b; co0 = o[0];
    end
    x.val = ref_res(o, a, b);
    x.due = cyc + lat;
    sb_q.push_back(x);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    cyc = 0; n_checks = 0; n_errors = 0; last_exp = 32'h0;
    cv = 1'b0; ca = 32'h0; cb = 32'h0; co0 = 1'b0;
    rst_n = 1'b0; start = 1'b1; op = 2'b00; a_in = 32'd5; b_in = 32'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    start = 1'b0;

    // Release reset and start on the very first edge.
    rst_n = 1'b1;
    drive(2'b00, 32'hFFFF_FFF9, 32'd2);        // -7/2 -> -3
    drain();
    drive(2'b10, 32'hFFFF_FFF9, 32'd2);        // -7%2 -> -1
    drain();
    drive(2'b01, 32'hFFFF_FFFF, 32'h10);
    drain();
    drive(2'b11, 32'hFFFF_FFFF, 32'h10);
    drain();

    // Special cases.
    drive(2'b00, 32'd5, 32'd0);
    drain();
    drive(2'b11, 32'h1234, 32'd0);
    drain();
    drive(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    drive(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    drive(2'b10, 32'h8000_0000, 32'd0);        // both special: zero wins
    drain();

    // Flush mid-calculation.
    start = 1'b1; op = 2'b00; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_before_flush", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(valid), 64'd0);
    chk("flush_c_out", 64'(c_out), 64'(last_exp));
    drive(2'b01, 32'd9, 32'd3);
    drain();

    // Flush and start together: start is dropped.
    flush = 1'b1; start = 1'b1; op = 2'b00; a_in = 32'd5; b_in = 32'd0;
    @(posedge clk); #1; flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("flush_start_valid", 64'(valid), 64'd0);
    chk("flush_start_busy", 64'(busy), 64'd0);

    // Back-to-back: REM issued in the DONE cycle of DIV.
    @(negedge clk);
    drive(2'b00, 32'd100, 32'd7);
    n = 0;
    while (!valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!valid) chk("b2b_wait_timeout", 64'd0, 64'd1);
    drive(2'b10, 32'd100, 32'd7);
    drain();

    // Random operations.
    for (int i = 0; i < 12; i++) begin
      logic [XLEN-1:0] ra;
      logic [XLEN-1:0] rb;
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      drive(2'($urandom), ra, rb);
      drain();
    end

    // Reset asserted mid-calculation aborts without valid.
    start = 1'b1; op = 2'b01; a_in = 32'd1000; b_in = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_c_out", 64'(c_out), 64'd0);
    cv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_idle_busy", 64'(busy), 64'd0);
    drive(2'b00, 32'd100, 32'd7);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the operand and result width (even, >= 8).
REQ-002 The module SHALL have parameter CNT_W, default $clog2(XLEN+1), giving the width of the iteration counter.
REQ-003 One clock; reset is asynchronous and active-low: clk (input, 1) is the only clock and rst_n (input, 1) is the reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a new operation, sampled on the clk rising edge.
REQ-005 The module SHALL have port op, input, 2 bits: funct3[1:0], where 00=DIV, 01=DIVU, 10=REM and 11=REMU.
REQ-006 The module SHALL have ports a_in and b_in, inputs, XLEN bits each: dividend and divisor.
REQ-007 The module SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-008 The module SHALL have port busy, output, 1 bit: high while an iterative operation is in progress.
REQ-009 The module SHALL have port valid, output, 1 bit: single-cycle pulse marking c_out as valid.
REQ-010 The module SHALL have port c_out, output, XLEN bits: the result.

Function
REQ-011 The block SHALL use an FSM with states IDLE, CALC and DONE; DONE lasts exactly one cycle and drives valid=1.
REQ-012 start SHALL be accepted in IDLE or DONE (back-to-back operation) and ignored in CALC.
REQ-013 On acceptance, the block SHALL latch op and a_in/b_in; it SHALL convert signed operands (op[0]=0) to magnitudes and record the quotient sign as a[XLEN-1]^b[XLEN-1] and the remainder sign as a[XLEN-1].
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle for exactly XLEN cycles, then go to DONE.
REQ-015 Normal-case latency SHALL be XLEN+1 cycles, so valid is high XLEN+1 edges after the edge that samples start.
REQ-016 The final quotient and remainder SHALL be negated when their recorded sign is 1; c_out SHALL be the quotient for op[1]=0 and the remainder for op[1]=1.
REQ-017 For divide-by-zero (b_in==0), the block SHALL bypass CALC and go straight to DONE, with a latency of 1 cycle.
REQ-018 For divide-by-zero, DIV/DIVU SHALL return all ones and REM/REMU SHALL return a_in.
REQ-019 For signed overflow (DIV/REM with a_in = 1 followed by XLEN-1 zeros and b_in = all ones), latency SHALL be 1 cycle; DIV SHALL return a_in and REM SHALL return 0.
REQ-020 If both special cases apply, divide-by-zero SHALL take priority.
REQ-021 busy SHALL equal (state==CALC).
REQ-022 c_out SHALL hold its last value until the next DONE.
REQ-023 flush SHALL force IDLE on the next edge without asserting valid, and SHALL leave c_out unchanged.
REQ-024 When flush and start occur in the same cycle, flush SHALL win and start SHALL be dropped.
REQ-025 Changes on a_in, b_in or op after acceptance SHALL have no effect on the in-flight result.

Reset
REQ-026 While rst_n=0, the block SHALL be held in state IDLE with busy=0, valid=0, c_out=0, counter=0, and the cache (if present) invalid.
REQ-027 Asserting rst_n mid-CALC SHALL abort the operation immediately, without asserting valid.
REQ-028 The first start SHALL be accepted on the first edge after rst_n deasserts.

Configuration
REQ-029 With macro DIV_RESULT_CACHE_EN defined, the block SHALL keep the last normal-case a, b, op[0], quotient and remainder plus a cache-valid bit, set at completion of a normal-case operation.
REQ-030 With DIV_RESULT_CACHE_EN defined, an accepted start with a_in, b_in and op[0] matching the cache SHALL go to DONE with a latency of 1 cycle and return the cached quotient or remainder selected by op[1].
REQ-031 Without DIV_RESULT_CACHE_EN, no cache storage SHALL exist and every normal-case operation SHALL take XLEN+1 cycles.

Verification (XLEN=32)
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> valid at +33 with c_out=0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-033 DIVU a=0xFFFFFFFF, b=0x10 -> c_out=0x0FFFFFFF at +33; REMU with the same operands -> 0xF.
REQ-034 DIV a=5, b=0 -> 0xFFFFFFFF at +1; REMU a=0x1234, b=0 -> 0x1234 at +1; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at +1; REM with the same operands -> 0.
REQ-035 DIV 100/7 started, flush at cycle 10 -> no valid and busy=0 next cycle; then DIVU 9/3 -> 3 at +33.
REQ-036 DIV 100/7 -> 14 at +33, then back-to-back REM 100/7 started in the DONE cycle -> 2 at +1 with DIV_RESULT_CACHE_EN, or at +33 without it.
